// File: rtl/output_mem_pkg.sv
// output_mem_pkg: geometry, scan-mode encoding and lane helpers for the WinoCNN output buffer.
package output_mem_pkg;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int LANES  = 16;
  localparam int LANE_W = 32;
  localparam int DATA_W = LANES * LANE_W;
  typedef enum logic [1:0] {SCAN_WR = 2'b00, ACCUM = 2'b01, IDLE = 2'b10, SCAN_RD = 2'b11} scan_mode_e;
  typedef logic signed [LANE_W-1:0] lane_t;
  function automatic logic [LANE_W+1:0] sext(lane_t v);
    return {{2{v[LANE_W-1]}}, v};
  endfunction
endpackage

// File: rtl/output_mem_if.sv
// output_mem_if: scan port plus the two accumulate ports of the output buffer.
interface output_mem_if;
  import output_mem_pkg::*;
  logic [DATA_W-1:0] scan_in;
  logic [ADDR_W-1:0] scan_addr;
  scan_mode_e        scan_mode;
  logic [DATA_W-1:0] scan_out;
  logic [ADDR_W-1:0] addr_1_in, addr_2_in, addr_1_out, addr_2_out;
  logic              package_1_valid_in, package_2_valid_in;
  logic              package_1_valid_out, package_2_valid_out;
  logic [DATA_W-1:0] data_1_in, data_2_in, data_1_out, data_2_out;
  modport master (
    output scan_in, scan_addr, scan_mode, addr_1_in, addr_2_in,
           package_1_valid_in, package_2_valid_in, data_1_in, data_2_in,
    input  scan_out, addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
           data_1_out, data_2_out
  );
  modport slave (
    input  scan_in, scan_addr, scan_mode, addr_1_in, addr_2_in,
           package_1_valid_in, package_2_valid_in, data_1_in, data_2_in,
    output scan_out, addr_1_out, addr_2_out, package_1_valid_out, package_2_valid_out,
           data_1_out, data_2_out
  );
endinterface

// File: rtl/output_mem_lane_add.sv
// output_mem_lane_add: lane-wise base + add_a + add_b; OUTPUT_MEM_SATURATE_EN clamps each lane to signed 32-bit.
module output_mem_lane_add import output_mem_pkg::*; (
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] add_a,
  input  logic [DATA_W-1:0] add_b,
  output logic [DATA_W-1:0] sum
);
  for (genvar i = 0; i < LANES; i++) begin : g_lane
`ifdef OUTPUT_MEM_SATURATE_EN
    logic [LANE_W+1:0] s;
    logic [2:0]        top;
    assign s   = sext(base[i*LANE_W +: LANE_W]) + sext(add_a[i*LANE_W +: LANE_W]) + sext(add_b[i*LANE_W +: LANE_W]);
    assign top = s[LANE_W+1:LANE_W-1];
    // three operands fit in 34 bits; top three bits disagreeing means the lane overflowed
    assign sum[i*LANE_W +: LANE_W] = (top == 3'b000 || top == 3'b111) ? s[LANE_W-1:0]
                                   : {s[LANE_W+1], {(LANE_W-1){~s[LANE_W+1]}}};
`else
    assign sum[i*LANE_W +: LANE_W] = base[i*LANE_W +: LANE_W] + add_a[i*LANE_W +: LANE_W] + add_b[i*LANE_W +: LANE_W];
`endif
  end
endmodule

// File: rtl/output_mem.sv
// output_mem: 256x512 partial-sum buffer with scan load/unload and two single-cycle accumulate ports.
// Define OUTPUT_MEM_SATURATE_EN for saturating lane adds.
module output_mem import output_mem_pkg::*; (
  input logic         clk,
  input logic         reset,
  output_mem_if.slave bus
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] sum_1, sum_2, add_b_1;
  logic [DATA_W-1:0] data_1_d, data_1_q, data_2_d, data_2_q, scan_out_d, scan_out_q;
  logic [ADDR_W-1:0] addr_1_d, addr_1_q, addr_2_d, addr_2_q;
  logic              valid_1_d, valid_1_q, valid_2_d, valid_2_q;
  logic              accum, coll, we_s, we_1, we_2;
  output_mem_lane_add u_add_1 (.base(mem_q[bus.addr_1_in]), .add_a(bus.data_1_in), .add_b(add_b_1), .sum(sum_1));
  output_mem_lane_add u_add_2 (.base(mem_q[bus.addr_2_in]), .add_a(bus.data_2_in), .add_b('0), .sum(sum_2));
  always_comb begin
    accum      = !reset && bus.scan_mode == ACCUM;
    coll       = bus.package_1_valid_in && bus.package_2_valid_in && bus.addr_1_in == bus.addr_2_in;
    add_b_1    = coll ? bus.data_2_in : '0;
    we_s       = !reset && bus.scan_mode == SCAN_WR;
    we_1       = accum && bus.package_1_valid_in;
    we_2       = accum && bus.package_2_valid_in && !coll;
    valid_1_d  = we_1;
    valid_2_d  = accum && bus.package_2_valid_in;
    data_1_d   = valid_1_d ? sum_1 : data_1_q;
    addr_1_d   = valid_1_d ? bus.addr_1_in : addr_1_q;
    data_2_d   = valid_2_d ? (coll ? sum_1 : sum_2) : data_2_q;
    addr_2_d   = valid_2_d ? bus.addr_2_in : addr_2_q;
    scan_out_d = bus.scan_mode == SCAN_RD ? mem_q[bus.scan_addr] : scan_out_q;
  end
  // a colliding pair is written once, through port 1, with the combined sum
  always_ff @(posedge clk) begin
    if (we_s) mem_q[bus.scan_addr] <= bus.scan_in;
    if (we_1) mem_q[bus.addr_1_in] <= sum_1;
    if (we_2) mem_q[bus.addr_2_in] <= sum_2;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_1_q   <= '0;
      data_2_q   <= '0;
      addr_1_q   <= '0;
      addr_2_q   <= '0;
      valid_1_q  <= 1'b0;
      valid_2_q  <= 1'b0;
      scan_out_q <= '0;
    end else begin
      data_1_q   <= data_1_d;
      data_2_q   <= data_2_d;
      addr_1_q   <= addr_1_d;
      addr_2_q   <= addr_2_d;
      valid_1_q  <= valid_1_d;
      valid_2_q  <= valid_2_d;
      scan_out_q <= scan_out_d;
    end
  end
  assign bus.data_1_out          = data_1_q;
  assign bus.data_2_out          = data_2_q;
  assign bus.addr_1_out          = addr_1_q;
  assign bus.addr_2_out          = addr_2_q;
  assign bus.package_1_valid_out = valid_1_q;
  assign bus.package_2_valid_out = valid_2_q;
  assign bus.scan_out            = scan_out_q;
endmodule

// File: tb/tb_output_mem.sv
// tb_output_mem: scoreboard bench for output_mem; a shadow memory predicts every output each cycle.
module tb_output_mem;
  import output_mem_pkg::*;
  typedef struct {int sel; logic [DATA_W-1:0] v;} exp_t;
  logic clk = 1'b0;
  logic reset;
  output_mem_if bus ();
  output_mem dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t              exp_q[$];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] h_d1, h_d2, h_scan;
  logic [ADDR_W-1:0] h_a1, h_a2;
  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  function automatic logic [DATA_W-1:0] ladd(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      longint s;
      s = longint'($signed(a[i*32 +: 32])) + longint'($signed(b[i*32 +: 32])) + longint'($signed(c[i*32 +: 32]));
`ifdef OUTPUT_MEM_SATURATE_EN
      if (s > 64'sd2147483647) s = 64'sd2147483647;
      else if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
      r[i*32 +: 32] = s[31:0];
    end
    return r;
  endfunction
  function automatic logic [DATA_W-1:0] fill(input logic [31:0] v);
    return {LANES{v}};
  endfunction
  function automatic logic [DATA_W-1:0] rnd();
    logic [DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  task automatic push(input int sel, input logic [DATA_W-1:0] v);
    exp_t e;
    e.sel = sel;
    e.v   = v;
    exp_q.push_back(e);
  endtask
  task automatic tick(input logic r, input scan_mode_e m, input logic [7:0] sa, input logic [DATA_W-1:0] si,
                      input logic v1, input logic [7:0] a1, input logic [DATA_W-1:0] d1,
                      input logic v2, input logic [7:0] a2, input logic [DATA_W-1:0] d2);
    logic [DATA_W-1:0] n1, n2;
    logic coll;
    reset = r; bus.scan_mode = m; bus.scan_addr = sa; bus.scan_in = si;
    bus.package_1_valid_in = v1; bus.addr_1_in = a1; bus.data_1_in = d1;
    bus.package_2_valid_in = v2; bus.addr_2_in = a2; bus.data_2_in = d2;
    if (r) begin
      h_d1 = '0; h_d2 = '0; h_a1 = '0; h_a2 = '0; h_scan = '0;
    end else if (m == SCAN_WR) model[sa] = si;
    else if (m == SCAN_RD) h_scan = model[sa];
    else if (m == ACCUM) begin
      coll = v1 && v2 && a1 == a2;
      n1 = ladd(model[a1], d1, coll ? d2 : '0);
      n2 = coll ? n1 : ladd(model[a2], d2, '0);
      if (v1) begin model[a1] = n1; h_d1 = n1; h_a1 = a1; end
      if (v2) begin model[a2] = n2; h_d2 = n2; h_a2 = a2; end
    end
    push(0, h_d1); push(1, h_d2); push(2, h_scan); push(3, DATA_W'(h_a1)); push(4, DATA_W'(h_a2));
    push(5, DATA_W'(!r && m == ACCUM && v1)); push(6, DATA_W'(!r && m == ACCUM && v2));
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      case (e.sel)
        0: chk("data_1_out", bus.data_1_out, e.v);
        1: chk("data_2_out", bus.data_2_out, e.v);
        2: chk("scan_out", bus.scan_out, e.v);
        3: chk("addr_1_out", DATA_W'(bus.addr_1_out), e.v);
        4: chk("addr_2_out", DATA_W'(bus.addr_2_out), e.v);
        5: chk("valid_1_out", DATA_W'(bus.package_1_valid_out), e.v);
        default: chk("valid_2_out", DATA_W'(bus.package_2_valid_out), e.v);
      endcase
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [DATA_W-1:0] v);
    tick(0, SCAN_WR, a, v, 0, 0, '0, 0, 0, '0);
  endtask
  task automatic rd(input logic [7:0] a);
    tick(0, SCAN_RD, a, '0, 0, 0, '0, 0, 0, '0);
  endtask
  task automatic acc(input logic v1, input logic [7:0] a1, input logic [DATA_W-1:0] d1,
                     input logic v2, input logic [7:0] a2, input logic [DATA_W-1:0] d2);
    tick(0, ACCUM, 8'h00, '0, v1, a1, d1, v2, a2, d2);
  endtask
  initial begin
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    tick(1, IDLE, 0, '0, 0, 0, '0, 0, 0, '0);
    tick(1, ACCUM, 0, '0, 1, 8'h03, fill(1), 1, 8'h04, fill(2));
    for (int i = 0; i < DEPTH; i++) wr(8'(i), '0);
    rd(8'h05);
    acc(1, 8'h05, fill(1), 1, 8'h0A, fill(1));
    wr(8'h05, '0); wr(8'h0A, '0);
    acc(1, 8'h05, fill(1), 0, 8'h00, fill(9));
    acc(1, 8'h01, fill(1), 0, 8'h00, fill(9));
    acc(1, 8'h05, fill(1), 0, 8'h00, fill(9));
    rd(8'h05); rd(8'h01);
    tick(0, IDLE, 8'h01, '0, 1, 8'h07, fill(5), 1, 8'h08, fill(5));
    acc(1, 8'h09, fill(3), 1, 8'h09, fill(4));
    rd(8'h09);
    w = '0; w[31:0] = 32'hFFFF_FFFF; w[63:32] = 32'd5;
    wr(8'h20, w);
    w = '0; w[31:0] = 32'd1;
    acc(1, 8'h20, w, 0, 8'h00, '0);
    rd(8'h20);
    w = '0; w[31:0] = 32'h7FFF_FFFF; w[63:32] = 32'h8000_0000;
    wr(8'h21, w);
    w = '0; w[31:0] = 32'd1; w[63:32] = 32'hFFFF_FFFF;
    acc(0, 8'h00, '0, 1, 8'h21, w);
    rd(8'h21);
    for (int i = 0; i < 80; i++) begin
      tick(0, scan_mode_e'($urandom_range(0, 3)), 8'($urandom_range(0, 7)), rnd(),
           1'($urandom), 8'($urandom_range(0, 7)), rnd(), 1'($urandom), 8'($urandom_range(0, 7)), rnd());
    end
    acc(1, 8'h02, fill(6), 0, 8'h00, '0);
    tick(1, ACCUM, 0, '0, 1, 8'h02, fill(1), 1, 8'h03, fill(1));
    rd(8'h02); rd(8'h03);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
